// File: rtl/uart_rx_axis_fifo.sv
// Elastic FWFT FIFO between the non-stallable UART receiver stream and an AXI-Stream master,
// with sticky overflow flag and saturating overflow / parity-error counters.
// Build option: define UART_RX_FIFO_DROP_ERR_EN to discard parity-error words instead of storing them.
module uart_rx_axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tuser,
  input  logic                     s_tvalid,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     overflow_cnt,
  output logic [CNT_WIDTH-1:0]     parity_err_cnt,
  input  logic                     cnt_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
`ifndef UART_RX_FIFO_DROP_ERR_EN
  logic                  mem_user [DEPTH];
`endif

  // Counters carry one extra wrap bit; the low AW bits are the actual pointers.
  logic [AW:0]   wr_cnt, rd_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, store_req, push, pop, drop, par_evt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    wr_ptr = wr_cnt[AW-1:0];
    rd_ptr = rd_cnt[AW-1:0];
    level  = wr_cnt - rd_cnt;
    full   = level[AW];
    empty  = (level == '0);
  end

  always_comb begin
`ifdef UART_RX_FIFO_DROP_ERR_EN
    store_req = s_tvalid & ~s_tuser;
`else
    store_req = s_tvalid;
`endif
    pop     = ~empty & m_tready;
    push    = store_req & (~full | pop);
    drop    = store_req & full & ~pop;
    par_evt = s_tvalid & s_tuser;
  end

  always_comb begin
    m_tvalid = ~empty;
    m_tdata  = empty ? '0 : mem_data[rd_ptr];
`ifdef UART_RX_FIFO_DROP_ERR_EN
    m_tuser  = 1'b0;
`else
    m_tuser  = empty ? 1'b0 : mem_user[rd_ptr];
`endif
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr] <= s_tdata;
`ifndef UART_RX_FIFO_DROP_ERR_EN
      mem_user[wr_ptr] <= s_tuser;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + 1'b1;
      if (pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // A new event in the clearing cycle wins over the clear and counts as the first event.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overflow       <= 1'b0;
      overflow_cnt   <= '0;
      parity_err_cnt <= '0;
    end else begin
      if (drop) begin
        overflow     <= 1'b1;
        overflow_cnt <= cnt_clear ? CNT_ONE : sat_inc(overflow_cnt);
      end else if (cnt_clear) begin
        overflow     <= 1'b0;
        overflow_cnt <= '0;
      end
      if (par_evt)
        parity_err_cnt <= cnt_clear ? CNT_ONE : sat_inc(parity_err_cnt);
      else if (cnt_clear)
        parity_err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Bench for uart_rx_axis_fifo: vector table with fixed expectations plus a queue scoreboard
// and a small behavioural model of level and counters.
module tb_uart_rx_axis_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tuser, s_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tuser, m_tvalid, m_tready;
  logic [4:0]    level;
  logic          overflow;
  logic [CW-1:0] overflow_cnt, parity_err_cnt;
  logic          cnt_clear;

  uart_rx_axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .level(level), .overflow(overflow), .overflow_cnt(overflow_cnt),
    .parity_err_cnt(parity_err_cnt), .cnt_clear(cnt_clear)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          u;
    logic          r;
    logic          c;
    int            lvl;
    logic          ovf;
    int            ocnt;
  } vec_t;

  vec_t          tbl[$];
  logic [DW:0]   sb[$];
  int            mlevel, mocnt, mpar;
  bit            movf;
  int            total = 0;
  int            passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    sb.delete();
    mlevel = 0; mocnt = 0; mpar = 0; movf = 1'b0;
  endtask

  // One clock cycle: drive, check any pop against the scoreboard, update the model, check state.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic u,
                       input logic r, input logic c);
    bit pop, st, push, drop;
    logic [DW:0] exp_w;
    s_tvalid = v; s_tdata = d; s_tuser = u; m_tready = r; cnt_clear = c;
    pop  = (mlevel > 0) && r;
    st   = v && !(DROP_ERR && u);
    push = st && ((mlevel < DEPTH) || pop);
    drop = st && !push;
    #3;
    if (m_tvalid && m_tready) begin
      check("sb_has_word", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        check("pop_tdata", m_tdata, exp_w[DW-1:0]);
        check("pop_tuser", m_tuser, exp_w[DW]);
      end
    end
    if (push) sb.push_back({(DROP_ERR ? 1'b0 : u), d});
    mlevel = mlevel + int'(push) - int'(pop);
    if (drop) begin
      movf  = 1'b1;
      mocnt = c ? 1 : ((mocnt == CMAX) ? CMAX : mocnt + 1);
    end else if (c) begin
      movf = 1'b0; mocnt = 0;
    end
    if (v && u) mpar = c ? 1 : ((mpar == CMAX) ? CMAX : mpar + 1);
    else if (c) mpar = 0;
    @(posedge aclk);
    #1;
    check("level", level, mlevel);
    check("m_tvalid", m_tvalid, mlevel != 0);
    check("overflow", overflow, movf);
    check("overflow_cnt", overflow_cnt, mocnt);
    check("parity_err_cnt", parity_err_cnt, mpar);
    if (mlevel == 0) begin
      check("empty_tdata", m_tdata, 0);
      check("empty_tuser", m_tuser, 0);
    end else if (sb.size() > 0) begin
      check("head_tdata", m_tdata, sb[0][DW-1:0]);
      check("head_tuser", m_tuser, sb[0][DW]);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; m_tready = 1'b0; cnt_clear = 1'b0;
    @(posedge aclk);
    #1;
    model_clear();
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_level", level, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_overflow", overflow, 0);
    check("rst_overflow_cnt", overflow_cnt, 0);
    check("rst_parity_err_cnt", parity_err_cnt, 0);
    aresetn = 1'b1;
  endtask

  initial begin
    vec_t t;
    // Fill 0x00..0x0F stalled, drain, refill, drop 0xAA, full push+pop of 0x55, drain.
    for (int i = 0; i < DEPTH; i++) tbl.push_back('{1, DW'(i), 0, 0, 0, i + 1, 0, 0});
    for (int i = 0; i < DEPTH; i++) tbl.push_back('{0, 8'h00, 0, 1, 0, DEPTH - 1 - i, 0, 0});
    for (int i = 0; i < DEPTH; i++) tbl.push_back('{1, DW'(i), 0, 0, 0, i + 1, 0, 0});
    tbl.push_back('{1, 8'hAA, 0, 0, 0, 16, 1, 1});
    tbl.push_back('{1, 8'h55, 0, 1, 0, 16, 1, 1});
    for (int i = 0; i < DEPTH; i++) tbl.push_back('{0, 8'h00, 0, 1, 0, DEPTH - 1 - i, 1, 1});

    do_reset();
    do_reset();

    foreach (tbl[i]) begin
      t = tbl[i];
      cycle(t.v, t.d, t.u, t.r, t.c);
      check($sformatf("tbl%0d_level", i), level, t.lvl);
      check($sformatf("tbl%0d_overflow", i), overflow, t.ovf);
      check($sformatf("tbl%0d_overflow_cnt", i), overflow_cnt, t.ocnt);
    end

    // Clear, then a parity-error word.
    cycle(0, 8'h00, 0, 0, 1);
    check("clear_overflow", overflow, 0);
    check("clear_overflow_cnt", overflow_cnt, 0);
    cycle(1, 8'h3C, 1, 1, 0);
    check("par_cnt_one", parity_err_cnt, 1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    check("par_dropped_level", level, 0);
    check("par_dropped_valid", m_tvalid, 0);
`else
    check("par_stored_level", level, 1);
    check("par_stored_tdata", m_tdata, 8'h3C);
    check("par_stored_tuser", m_tuser, 1);
`endif
    cycle(0, 8'h00, 0, 1, 0);
    check("par_drained", level, 0);

    // Mid-operation reset with stored words and non-zero counters.
    cycle(1, 8'h11, 1, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, DW'(8'h20 + i), 0, 0, 0);
    check("pre_rst_overflow", overflow, 1);
    do_reset();

    // Overflow counter saturation, then clear coinciding with a drop.
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'hBB, 0, 0, 0);
      check($sformatf("sat_ocnt%0d", i), overflow_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
    end
    check("sat_level", level, 16);
    cycle(1, 8'hEE, 0, 0, 1);
    check("clr_drop_overflow", overflow, 1);
    check("clr_drop_ocnt", overflow_cnt, 1);
    cycle(0, 8'h00, 0, 0, 1);
    check("clr_only_overflow", overflow, 0);
    check("clr_only_ocnt", overflow_cnt, 0);

    // Parity counter saturation and clear coinciding with a parity word.
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 1, 0, 0);
    check("sat_parity", parity_err_cnt, CMAX);
    cycle(1, 8'h77, 1, 0, 1);
    check("clr_par_cnt", parity_err_cnt, 1);

    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 8'h00, 0, 1, 0);
    check("final_level", level, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
